// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative unsigned MULT/DIV into HI/LO.
// Latency: single-cycle ops 1 cycle; MULT/DIV WIDTH cycles; start is ignored while busy (no queueing).
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MULT = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  // Single-cycle datapath
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_res, sub_res, b_neg, sra_res;
  logic             ovf_add, ovf_sub;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;

  assign shamt   = b[SHW-1:0];
  assign add_res = a + b;
  assign sub_res = a - b;
  assign b_neg   = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
  assign sra_res = $signed(a) >>> shamt;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1])     & (add_res[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] == b_neg[WIDTH-1]) & (sub_res[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_control)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD:  begin sc_res = add_res; sc_ovf = ovf_add; end
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = sra_res;
      OP_SUB:  begin sc_res = sub_res; sc_ovf = ovf_sub; end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  sc_res = ~(a | b);
      default: sc_res = '0;
    endcase
  end

  // One iteration step. MULT: {acc,lo} is the shifting product with the multiplier in lo.
  // DIV: acc is the partial remainder, lo shifts the dividend out and the quotient in.
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic [WIDTH-1:0] step_acc, step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_rem  = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    if (is_div_q) begin
      step_acc = div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    lo_d          = lo_q;
    opnd_d        = opnd_q;
    is_div_d      = is_div_q;
    result_d      = result_q;
    result_hi_d   = result_hi_q;
    zero_d        = zero_q;
    overflow_d    = overflow_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          overflow_d    = 1'b0;
          div_by_zero_d = 1'b0;
          if (alu_control == OP_MULT) begin
            state_d  = ITER;
            cnt_d    = '0;
            acc_d    = '0;
            lo_d     = b;
            opnd_d   = a;
            is_div_d = 1'b0;
          end else if (alu_control == OP_DIV && b != '0) begin
            state_d  = ITER;
            cnt_d    = '0;
            acc_d    = '0;
            lo_d     = a;
            opnd_d   = b;
            is_div_d = 1'b1;
          end else if (alu_control == OP_DIV) begin
            result_d      = '1;
            result_hi_d   = a;
            zero_d        = 1'b0;
            div_by_zero_d = 1'b1;
            done_d        = 1'b1;
          end else begin
            result_d    = sc_res;
            result_hi_d = '0;
            zero_d      = (sc_res == '0);
            overflow_d  = sc_ovf;
            done_d      = 1'b1;
          end
        end
      end
      ITER: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d     = IDLE;
          result_d    = step_lo;
          result_hi_d = step_acc;
          zero_d      = (step_lo == '0);
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      lo_q          <= '0;
      opnd_q        <= '0;
      is_div_q      <= 1'b0;
      result_q      <= '0;
      result_hi_q   <= '0;
      zero_q        <= 1'b0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      lo_q          <= lo_d;
      opnd_q        <= opnd_d;
      is_div_q      <= is_div_d;
      result_q      <= result_d;
      result_hi_q   <= result_hi_d;
      zero_q        <= zero_d;
      overflow_q    <= overflow_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;
  assign busy        = (state_q == ITER);
  assign done        = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed corner cases plus random ops against an arithmetic reference model.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] result, result_hi;
  logic         zero, overflow, div_by_zero, busy, done;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_control(alu_control),
    .result(result), .result_hi(result_hi), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        o;
    logic        d;
    logic        iter;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      s;
    logic [31:0] yn;
    logic [63:0] p;
    int          sx;
    e  = '0;
    sx = $signed(x);
    case (op)
      4'd0:  e.lo = x & y;
      4'd1:  e.lo = x | y;
      4'd2: begin
        e.lo = x + y;
        s    = longint'($signed(x)) + longint'($signed(y));
        e.o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        e.lo = x - y;
        yn   = 32'd0 - y;
        s    = longint'($signed(x)) + longint'($signed(yn));
        e.o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3:  e.lo = x << y[4:0];
      4'd4:  e.lo = x >> y[4:0];
      4'd5:  e.lo = 32'(sx >>> y[4:0]);
      4'd7:  e.lo = {31'd0, ($signed(x) < $signed(y))};
      4'd8:  e.lo = {31'd0, (x < y)};
      4'd9: begin
        p      = 64'(x) * 64'(y);
        e.hi   = p[63:32];
        e.lo   = p[31:0];
        e.iter = 1'b1;
      end
      4'd10: begin
        if (y == 0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = x;
          e.d  = 1'b1;
        end else begin
          e.lo   = x / y;
          e.hi   = x % y;
          e.iter = 1'b1;
        end
      end
      4'd12: e.lo = ~(x | y);
      default: e.lo = 32'd0;
    endcase
    e.z = (e.lo == 32'd0);
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob,
                        input string tag);
    exp_t e;
    int   cyc;
    logic busy_gap;
    e = model(op, oa, ob);
    @(negedge clk);
    start = 1'b1; alu_control = op; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0;
    if (e.iter) begin
      chk({tag, "_busy_at_accept"}, 64'(busy), 64'd1);
      cyc = 0;
      busy_gap = 1'b0;
      while (done !== 1'b1 && cyc < 3 * W) begin
        if (busy !== 1'b1) busy_gap = 1'b1;
        @(negedge clk);
        // junk requests and operand changes while busy must be ignored
        start = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; alu_control = 4'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
      chk({tag, "_cycles"}, 64'(cyc), 64'(W));
      chk({tag, "_busy_gap"}, 64'(busy_gap), 64'd0);
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_lo"}, 64'(result), 64'(e.lo));
    chk({tag, "_hi"}, 64'(result_hi), 64'(e.hi));
    chk({tag, "_zero"}, 64'(zero), 64'(e.z));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e.o));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e.d));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lo"}, 64'(result), 64'd0);
    chk({tag, "_hi"}, 64'(result_hi), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic        done_seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    run_op(4'b0110, 32'd5, 32'd5, "sub_zero");
    run_op(4'b0110, 32'h8000_0000, 32'd1, "sub_ovf");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(4'b0101, 32'h8000_0000, 32'd4, "sra");
    run_op(4'b0011, 32'd1, 32'h25, "sll_mask");
    run_op(4'b0100, 32'hDEAD_BEEF, 32'd0, "srl_by0");
    run_op(4'b1100, 32'd0, 32'd0, "nor");
    run_op(4'b1001, 32'hFFFF_FFFF, 32'd2, "mult");
    run_op(4'b1010, 32'd100, 32'd7, "div");
    run_op(4'b1010, 32'd9, 32'd0, "div0");
    run_op(4'b0010, 32'd2, 32'd3, "add_clr_dbz");
    run_op(4'b1111, 32'h1234, 32'h5678, "undef_op");
    run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_max");
    run_op(4'b1010, 32'd3, 32'hFFFF_FFFF, "div_small");
    run_op(4'b0010, 32'd1, 32'd1, "pre_reset");

    // Abort a MULT with reset mid-iteration
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1001; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk("rst_no_done", 64'(done_seen), 64'd0);
    run_op(4'b0010, 32'd3, 32'd4, "post_rst_add");

    repeat (80) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra & 32'h8000_000F;
      run_op(rop, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
